// File: rtl/divider_monitor.sv
// rtl/divider_monitor.sv - period/high-time monitor for divider outputs (optional macro SYNC_EN adds an input synchronizer)
module divider_monitor #(
  parameter int W          = 16,
  parameter int EXP_PERIOD = 32,
  parameter int EXP_HIGH   = 16,
  parameter int TOL        = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         meas_valid,
  output logic         match,
  output logic         stuck,
  output logic [7:0]   err_count
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] EXP_P   = W'(EXP_PERIOD);
  localparam logic [W-1:0] EXP_H   = W'(EXP_HIGH);
  localparam logic [W-1:0] TOL_W   = W'(TOL);
  // quiet reaches TIMEOUT on the same edge that sets stuck
  localparam logic [W-1:0] TO_LAST = W'(TIMEOUT - 1);

  logic         sig_src;
  logic         sig_d, sig_q;
  logic         rise, fall;
  logic [W-1:0] cnt;
  logic [W-1:0] quiet;
  logic [W-1:0] hi_q;
  logic         timeout;
  logic [W-1:0] p_diff, h_diff;
  logic         meas_ok;
  logic         latch_hi, publish;
  state_t       state_q, state_d;

`ifdef SYNC_EN
  logic sync_a, sync_b;

  // two-flop synchronizer so sig_in may come from another clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= sig_in;
      sync_b <= sync_a;
    end
  end

  assign sig_src = sync_b;
`else
  assign sig_src = sig_in;
`endif

  // edge history: sig_d is the current sample, sig_q the previous one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_d <= 1'b0;
      sig_q <= 1'b0;
    end else begin
      sig_d <= sig_src;
      sig_q <= sig_d;
    end
  end

  assign rise    = sig_d & ~sig_q;
  assign fall    = ~sig_d & sig_q;
  assign timeout = ~rise & ~fall & (quiet == TO_LAST);

  // cnt restarts at each rise, so it reads the high time on a fall and the period on a rise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= {{(W-1){1'b0}}, 1'b1};
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // quiet counts cycles since the last edge of either polarity, for stuck detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quiet <= '0;
    end else if (rise || fall) begin
      quiet <= {{(W-1){1'b0}}, 1'b1};
    end else if (quiet != CNT_MAX) begin
      quiet <= quiet + 1'b1;
    end
  end

  // absolute deviation of the finishing measurement from the expected values
  always_comb begin
    p_diff = (cnt  >= EXP_P) ? (cnt  - EXP_P) : (EXP_P - cnt);
    h_diff = (hi_q >= EXP_H) ? (hi_q - EXP_H) : (EXP_H - hi_q);
  end

  assign meas_ok = (p_diff <= TOL_W) && (h_diff <= TOL_W);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: first rise after IDLE only arms, a rise in LOW closes a full period
  always_comb begin
    state_d  = state_q;
    latch_hi = 1'b0;
    publish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (fall) begin
          latch_hi = 1'b1;
          state_d  = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          publish = 1'b1;
          state_d = HIGH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  // capture the high time at the falling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
    end else if (latch_hi) begin
      hi_q <= cnt;
    end
  end

  // publish results; outputs hold between publishes and across a stuck period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period     <= '0;
      high_time  <= '0;
      match      <= 1'b0;
      meas_valid <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      meas_valid <= publish;
      if (publish) begin
        period    <= cnt;
        high_time <= hi_q;
        match     <= meas_ok;
        if (!meas_ok && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end
    end
  end

  // stuck sets after TIMEOUT edge-free cycles and clears on the next rise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stuck <= 1'b0;
    end else if (timeout) begin
      stuck <= 1'b1;
    end else if (rise) begin
      stuck <= 1'b0;
    end
  end

endmodule

// File: tb/tb_divider_monitor.sv
// tb/tb_divider_monitor.sv - directed self-checking bench for divider_monitor
module tb_divider_monitor;

`ifdef SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif
  localparam int TIMEOUT = 1024;
  localparam int LAT     = 2 + SD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sig = 1'b0;

  logic [15:0] period_a, high_a, period_b, high_b, period_c, high_c;
  logic        mv_a, match_a, stuck_a;
  logic        mv_b, match_b, stuck_b;
  logic        mv_c, match_c, stuck_c;
  logic [7:0]  err_a, err_b, err_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mv_cnt_a = 0, mv_cnt_b = 0;
  int last_a = 0, prev_a = 0, last_b = 0, prev_b = 0;
  int k, first, base;

  always #5 clk = ~clk;

  divider_monitor dut_a (
    .clk(clk), .rst(rst), .sig_in(sig), .period(period_a), .high_time(high_a),
    .meas_valid(mv_a), .match(match_a), .stuck(stuck_a), .err_count(err_a)
  );

  divider_monitor #(.EXP_PERIOD(3), .EXP_HIGH(1)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig), .period(period_b), .high_time(high_b),
    .meas_valid(mv_b), .match(match_b), .stuck(stuck_b), .err_count(err_b)
  );

  divider_monitor #(.EXP_PERIOD(200), .EXP_HIGH(100), .TOL(1)) dut_c (
    .clk(clk), .rst(rst), .sig_in(sig), .period(period_c), .high_time(high_c),
    .meas_valid(mv_c), .match(match_c), .stuck(stuck_c), .err_count(err_c)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mv_a) begin
      mv_cnt_a++;
      prev_a = last_a;
      last_a = cyc;
    end
    if (mv_b) begin
      mv_cnt_b++;
      prev_b = last_b;
      last_b = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      sig = 1'b1;
      repeat (hi) @(negedge clk);
      sig = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    sig = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_period", period_a, 0);
    check_eq("rst_high", high_a, 0);
    check_eq("rst_mv", mv_a, 0);
    check_eq("rst_match", match_a, 0);
    check_eq("rst_stuck", stuck_a, 0);
    check_eq("rst_err", err_a, 0);
    rst = 1'b1;
    @(negedge clk);

    // divide-by-32, 50% duty: 4 rises give 3 publishes
    drive_wave(16, 16, 1);
    sig = 1'b1;
    k = 0;
    while (k < 8 && !mv_a) begin
      @(negedge clk);
      k++;
    end
    check_eq("a_latency", k, LAT);
    repeat (16 - k) @(negedge clk);
    sig = 1'b0;
    repeat (16) @(negedge clk);
    drive_wave(16, 16, 2);
    check_eq("a_mv_count", mv_cnt_a, 3);
    check_eq("a_spacing", last_a - prev_a, 32);
    check_eq("a_period", period_a, 32);
    check_eq("a_high", high_a, 16);
    check_eq("a_match", match_a, 1);
    check_eq("a_err", err_a, 0);
    check_eq("a_b_err", err_b, 3);
    check_eq("a_c_err", err_c, 3);

    // 33% duty divide-by-3, minimum-width high
    do_reset();
    base = mv_cnt_b;
    drive_wave(1, 2, 5);
    repeat (4) @(negedge clk);
    check_eq("b_mv_count", mv_cnt_b - base, 4);
    check_eq("b_spacing", last_b - prev_b, 3);
    check_eq("b_period", period_b, 3);
    check_eq("b_high", high_b, 1);
    check_eq("b_match", match_b, 1);
    check_eq("b_err", err_b, 0);
    check_eq("b_a_err", err_a, 4);

    // divide-by-200 with TOL=1, then 202 and 201 periods
    do_reset();
    drive_wave(100, 100, 3);
    check_eq("c_period", period_c, 200);
    check_eq("c_high", high_c, 100);
    check_eq("c_match", match_c, 1);
    check_eq("c_err", err_c, 0);
    drive_wave(100, 102, 1);
    drive_wave(100, 101, 1);
    check_eq("c202_period", period_c, 202);
    check_eq("c202_match", match_c, 0);
    check_eq("c202_err", err_c, 1);
    drive_wave(100, 100, 1);
    check_eq("c201_period", period_c, 201);
    check_eq("c201_match", match_c, 1);
    check_eq("c201_err", err_c, 1);

    // timeout after locking
    do_reset();
    drive_wave(16, 16, 2);
    sig = 1'b1;
    repeat (16) @(negedge clk);
    sig = 1'b0;
    base = mv_cnt_a;
    first = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      if (stuck_a && first == 0) first = i;
    end
    check_eq("to_when", first, TIMEOUT + 1 + SD);
    check_eq("to_stuck", stuck_a, 1);
    check_eq("to_hold_period", period_a, 32);
    check_eq("to_hold_high", high_a, 16);
    check_eq("to_hold_match", match_a, 1);
    check_eq("to_no_mv", mv_cnt_a - base, 0);
    drive_wave(16, 16, 1);
    check_eq("to_clear", stuck_a, 0);
    check_eq("to_clear_no_mv", mv_cnt_a - base, 0);
    drive_wave(16, 16, 1);
    repeat (4) @(negedge clk);
    check_eq("to_resume_mv", mv_cnt_a - base, 1);
    check_eq("to_resume_period", period_a, 32);

    // asynchronous reset mid-high, then a second short pulse
    do_reset();
    drive_wave(16, 16, 2);
    check_eq("ar_pre_period", period_a, 32);
    sig = 1'b1;
    repeat (8) @(negedge clk);
    #2;
    rst = 1'b0;
    sig = 1'b0;
    #1;
    check_eq("ar_period", period_a, 0);
    check_eq("ar_high", high_a, 0);
    check_eq("ar_match", match_a, 0);
    check_eq("ar_b_err", err_b, 0);
    check_eq("ar_mv", mv_a, 0);
    check_eq("ar_stuck", stuck_a, 0);
    #79;
    rst = 1'b1;
    #30;
    rst = 1'b0;
    #1;
    check_eq("ar2_c_err", err_c, 0);
    check_eq("ar2_period", period_a, 0);
    #19;
    rst = 1'b1;
    @(negedge clk);
    base = mv_cnt_a;
    drive_wave(16, 16, 1);
    check_eq("ar_first_no_mv", mv_cnt_a - base, 0);
    drive_wave(16, 16, 1);
    check_eq("ar_second_mv", mv_cnt_a - base, 1);
    check_eq("ar_second_period", period_a, 32);

    // mismatched waveform until err_count saturates
    do_reset();
    drive_wave(1, 2, 200);
    repeat (4) @(negedge clk);
    check_eq("sat_mid_err", err_a, 199);
    check_eq("sat_mid_b_err", err_b, 0);
    drive_wave(1, 2, 100);
    repeat (4) @(negedge clk);
    check_eq("sat_err", err_a, 255);
    check_eq("sat_period", period_a, 3);
    check_eq("sat_b_err", err_b, 1);
    check_eq("sat_b_match", match_b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
